// File: rtl/uart_dbg_master.sv
// UART debug bus initiator: decodes 'W'/'R' command frames from the serial line, performs one
// single-word bus access with a one-cycle hold lead-in, and replies ACK, NAK or read data.
module uart_dbg_master #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic        m_req_o,
    output logic        m_we_o,
    input  logic [31:0] m_rdata_i,
    output logic        hold_o,
    output logic        busy_o
);
    localparam int DIV    = CLK_FREQ / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int CW     = $clog2(DIV);
    localparam int TO_LIM = TIMEOUT_BITS * DIV;
    localparam int TW     = $clog2(TO_LIM + 2);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_HOLD, S_ACCESS, S_RESP} state_t;
    state_t r_state, w_next;

    logic          r_rx_s1, r_rx_s2, r_rx_s3;
    logic          r_rx_busy, r_rx_keep, r_rx_valid, r_rx_ferr;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;
    logic          w_rx_accept;

    logic          r_tx_busy, r_tx_stage_vld;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic [9:0]    r_tx_sh;
    logic [7:0]    r_tx_stage;
    logic          w_tx_we;
    logic [7:0]    w_tx_data;

    logic [7:0]    r_cmd;
    logic [31:0]   r_addr, r_data, r_resp, r_m_addr, r_m_wdata;
    logic [1:0]    r_byte_cnt;
    logic [2:0]    r_resp_len;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;

    assign uart_tx_o   = r_tx_sh[0];
    assign m_addr_o    = r_m_addr;
    assign m_wdata_o   = r_m_wdata;
    assign w_tx_data   = r_resp[7:0];
    assign w_timeout   = (r_to_cnt > TW'(TO_LIM));
    // Only bytes whose start bit falls while a frame can still be decoded are delivered.
    assign w_rx_accept = (r_state == S_IDLE) || (r_state == S_CMD) ||
                         (r_state == S_ADDR) || (r_state == S_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_keep  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
        end else begin
            r_rx_s1    <= uart_rx_i;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            if (!r_rx_busy) begin
                if (r_rx_s3 && !r_rx_s2) begin
                    r_rx_busy <= 1'b1;
                    r_rx_keep <= w_rx_accept;
                    r_rx_cnt  <= '0;
                    r_rx_bit  <= '0;
                end
            end else if (r_rx_bit == 4'd0) begin
                if (r_rx_cnt == CW'(HALF - 1)) begin
                    r_rx_cnt <= '0;
                    if (r_rx_s2) r_rx_busy <= 1'b0;
                    else         r_rx_bit  <= 4'd1;
                end else begin
                    r_rx_cnt <= r_rx_cnt + CW'(1);
                end
            end else if (r_rx_cnt == CW'(DIV - 1)) begin
                r_rx_cnt <= '0;
                if (r_rx_bit == 4'd9) begin
                    r_rx_busy  <= 1'b0;
                    r_rx_valid <= r_rx_keep & r_rx_s2;
                    r_rx_ferr  <= r_rx_keep & ~r_rx_s2;
                end else begin
                    r_rx_bit <= r_rx_bit + 4'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_rx_busy && r_rx_bit != 4'd0 && r_rx_bit != 4'd9 && r_rx_cnt == CW'(DIV - 1))
            r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
        if (w_tx_we)
            r_tx_stage <= w_tx_data;
    end

    // Shifter reloads straight from the stage at the end of a stop bit so replies are gapless.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_busy      <= 1'b0;
            r_tx_stage_vld <= 1'b0;
            r_tx_cnt       <= '0;
            r_tx_bit       <= '0;
            r_tx_sh        <= '1;
        end else begin
            if (w_tx_we)
                r_tx_stage_vld <= 1'b1;
            if (!r_tx_busy || (r_tx_cnt == CW'(DIV - 1) && r_tx_bit == 4'd9)) begin
                r_tx_cnt <= '0;
                r_tx_bit <= '0;
                if (r_tx_stage_vld) begin
                    r_tx_sh        <= {1'b1, r_tx_stage, 1'b0};
                    r_tx_busy      <= 1'b1;
                    r_tx_stage_vld <= 1'b0;
                end else begin
                    r_tx_sh   <= '1;
                    r_tx_busy <= 1'b0;
                end
            end else if (r_tx_cnt == CW'(DIV - 1)) begin
                r_tx_cnt <= '0;
                r_tx_bit <= r_tx_bit + 4'd1;
                r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
            end else begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_tx_we = 1'b0;
        hold_o  = 1'b0;
        m_req_o = 1'b0;
        m_we_o  = 1'b0;
        busy_o  = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   if (r_rx_valid) w_next = S_CMD;
            S_CMD:    w_next = (r_cmd == CMD_W || r_cmd == CMD_R) ? S_ADDR : S_RESP;
            S_ADDR: begin
                if (r_rx_ferr || w_timeout)
                    w_next = S_IDLE;
                else if (r_rx_valid && r_byte_cnt == 2'd3)
                    w_next = (r_cmd == CMD_W) ? S_DATA : S_HOLD;
            end
            S_DATA: begin
                if (r_rx_ferr || w_timeout)
                    w_next = S_IDLE;
                else if (r_rx_valid && r_byte_cnt == 2'd3)
                    w_next = S_HOLD;
            end
            S_HOLD: begin
                hold_o = 1'b1;
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                hold_o  = 1'b1;
                m_req_o = 1'b1;
                m_we_o  = (r_cmd == CMD_W);
                w_next  = S_RESP;
            end
            S_RESP: begin
                if (!r_tx_stage_vld) begin
                    w_tx_we = 1'b1;
                    if (r_resp_len == 3'd1) w_next = S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_resp_len <= '0;
            r_to_cnt   <= '0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
        end else begin
            r_to_cnt <= '0;
            case (r_state)
                S_CMD: begin
                    r_byte_cnt <= '0;
                    r_resp_len <= 3'd1;
                end
                S_ADDR, S_DATA: begin
                    if (r_rx_valid)     r_byte_cnt <= r_byte_cnt + 2'd1;
                    else if (!r_rx_busy) r_to_cnt  <= r_to_cnt + TW'(1);
                end
                S_HOLD: begin
                    r_m_addr <= r_addr;
                    if (r_cmd == CMD_W) r_m_wdata <= r_data;
                end
                S_ACCESS: r_resp_len <= (r_cmd == CMD_W) ? 3'd1 : 3'd4;
                S_RESP:   if (!r_tx_stage_vld) r_resp_len <= r_resp_len - 3'd1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE:   if (r_rx_valid) r_cmd <= r_rx_sh;
            S_CMD:    r_resp <= 32'h0000_0015;
            S_ADDR:   if (r_rx_valid) r_addr <= {r_rx_sh, r_addr[31:8]};
            S_DATA:   if (r_rx_valid) r_data <= {r_rx_sh, r_data[31:8]};
            S_ACCESS: r_resp <= (r_cmd == CMD_W) ? 32'h0000_0006 : m_rdata_i;
            S_RESP:   if (!r_tx_stage_vld) r_resp <= {8'h00, r_resp[31:8]};
            default:  ;
        endcase
    end
endmodule

// File: tb/tb_uart_dbg_master.sv
// Bench for uart_dbg_master: serial frames in, bus accesses and reply bytes compared against
// a frame-level reference model; hold/req timing checked around every access.
`timescale 1ns/1ps
module tb_uart_dbg_master;
    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx_i = 1'b1;
    logic        uart_tx_o;
    logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
    logic        m_req_o, m_we_o, hold_o, busy_o;
    logic [31:0] rdata_val = 32'h0;

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} acc_t;
    acc_t       exp_acc[$], got_acc[$];
    logic [7:0] exp_tx[$], got_tx[$];
    logic [7:0] fr [0:8];
    int         fn = 0;
    int         n_total = 0, n_bad = 0;
    logic       req_d1 = 1'b0, hold_d1 = 1'b0, hold_d2 = 1'b0;

    assign m_rdata_i = rdata_val;

    uart_dbg_master #(.CLK_FREQ(1_000_000), .BAUD(100_000), .TIMEOUT_BITS(64)) dut (
        .clk(clk), .rst(rst), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
        .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_req_o(m_req_o), .m_we_o(m_we_o),
        .m_rdata_i(m_rdata_i), .hold_o(hold_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx_i = stop;
        repeat (DIV) @(negedge clk);
        uart_rx_i = 1'b1;
        if (!stop) repeat (DIV) @(negedge clk);
    endtask

    task automatic mk_w(input logic [31:0] a, input logic [31:0] d);
        fr[0] = 8'h57;
        for (int k = 0; k < 4; k++) begin
            fr[1+k] = 8'((a >> (8*k)) & 32'hFF);
            fr[5+k] = 8'((d >> (8*k)) & 32'hFF);
        end
        fn = 9;
    endtask

    task automatic mk_r(input logic [31:0] a);
        fr[0] = 8'h52;
        for (int k = 0; k < 4; k++) fr[1+k] = 8'((a >> (8*k)) & 32'hFF);
        fn = 5;
    endtask

    // Frame-level model: fields reassembled little-endian by arithmetic, reply chosen by command.
    task automatic model_frame();
        acc_t e;
        logic [31:0] a, d;
        a = 0;
        d = 0;
        for (int k = 0; k < 4; k++) begin
            if (fn >= 5) a = a + (32'(fr[1+k]) << (8*k));
            if (fn >= 9) d = d + (32'(fr[5+k]) << (8*k));
        end
        if (fr[0] == 8'h57) begin
            e.we = 1'b1; e.addr = a; e.wdata = d;
            exp_acc.push_back(e);
            exp_tx.push_back(8'h06);
        end else if (fr[0] == 8'h52) begin
            e.we = 1'b0; e.addr = a; e.wdata = 32'h0;
            exp_acc.push_back(e);
            for (int k = 0; k < 4; k++) exp_tx.push_back(8'((rdata_val >> (8*k)) % 256));
        end else begin
            exp_tx.push_back(8'h15);
        end
    endtask

    task automatic send_frame(input int gapmax);
        for (int i = 0; i < fn; i++) begin
            send_byte(fr[i], 1'b1);
            if (i == 0 && fn > 1) chk("busy_in_frame", busy_o, 1);
            repeat ($urandom_range(0, gapmax)) @(negedge clk);
        end
    endtask

    task automatic settle_and_check(input int clocks);
        repeat (clocks) @(negedge clk);
        chk("n_access", 32'(got_acc.size()), 32'(exp_acc.size()));
        for (int i = 0; i < exp_acc.size() && i < got_acc.size(); i++) begin
            chk("acc_we", got_acc[i].we, exp_acc[i].we);
            chk("acc_addr", got_acc[i].addr, exp_acc[i].addr);
            if (exp_acc[i].we) chk("acc_wdata", got_acc[i].wdata, exp_acc[i].wdata);
        end
        chk("n_tx_bytes", 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
            chk("tx_byte", got_tx[i], exp_tx[i]);
        exp_acc.delete(); got_acc.delete(); exp_tx.delete(); got_tx.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            req_d1  <= 1'b0;
            hold_d1 <= 1'b0;
            hold_d2 <= 1'b0;
        end else begin
            if (req_d1) begin
                chk("hold_fall_after_req", hold_o, 0);
                chk("req_one_cycle", m_req_o, 0);
            end
            if (m_req_o) begin
                chk("hold_before_req", hold_d1, 1);
                chk("hold_rise_1cyc", hold_d2, 0);
                chk("hold_during_req", hold_o, 1);
                got_acc.push_back({m_we_o, m_addr_o, m_wdata_o});
            end
            req_d1  <= m_req_o;
            hold_d1 <= hold_o;
            hold_d2 <= hold_d1;
        end
    end

    initial begin
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx_o === 1'b0) begin
                repeat (DIV/2) @(negedge clk);
                chk("tx_start_bit", uart_tx_o, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = uart_tx_o;
                end
                repeat (DIV) @(negedge clk);
                chk("tx_stop_bit", uart_tx_o, 1);
                got_tx.push_back(b);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx_o, 1);
        chk("rst_req", m_req_o, 0);
        chk("rst_we", m_we_o, 0);
        chk("rst_addr", m_addr_o, 0);
        chk("rst_wdata", m_wdata_o, 0);
        chk("rst_hold", hold_o, 0);
        chk("rst_busy", busy_o, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        mk_w(32'h2000_0000, 32'hDEAD_BEEF); model_frame(); send_frame(0);
        settle_and_check(600);
        chk("t1_addr_out", m_addr_o, 32'h2000_0000);
        chk("t1_wdata_out", m_wdata_o, 32'hDEAD_BEEF);
        chk("t1_idle", busy_o, 0);

        rdata_val = 32'h1234_5678;
        mk_r(32'h2000_0000); model_frame(); send_frame(0);
        settle_and_check(600);

        fr[0] = 8'h41; fn = 1; model_frame(); send_frame(0);
        settle_and_check(300);
        send_byte(8'h52, 1'b0);
        settle_and_check(300);
        send_byte(8'h57, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b0);
        settle_and_check(300);
        chk("ferr_idle", busy_o, 0);
        rdata_val = 32'hA5C3_0F81;
        mk_r(32'h0000_1004); model_frame(); send_frame(5);
        settle_and_check(600);

        send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        repeat (700) @(negedge clk);
        chk("timeout_idle", busy_o, 0);
        settle_and_check(10);
        rdata_val = 32'h0BAD_F00D;
        mk_r(32'h4000_0010); model_frame(); send_frame(0);
        settle_and_check(600);

        send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (4*DIV) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk("t5_tx", uart_tx_o, 1);
                chk("t5_req", m_req_o, 0);
                chk("t5_hold", hold_o, 0);
                chk("t5_busy", busy_o, 0);
                chk("t5_addr", m_addr_o, 0);
                chk("t5_wdata", m_wdata_o, 0);
                rst = 1'b0;
            end
        join
        settle_and_check(600);
        mk_w(32'h8000_00FC, 32'h0102_0304); model_frame(); send_frame(0);
        settle_and_check(600);

        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0: mk_w($urandom, $urandom);
                1: begin rdata_val = $urandom; mk_r($urandom); end
                default: begin
                    c = 8'($urandom_range(0, 255));
                    while (c == 8'h57 || c == 8'h52) c = 8'($urandom_range(0, 255));
                    fr[0] = c; fn = 1;
                end
            endcase
            model_frame();
            send_frame(40);
            settle_and_check(600);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
